// File: rtl/imem_pkg.sv
// imem_pkg: shared types and default sizing for the loadable instruction memory.
//   imem_state_t  controller states (CLEAR, READY, LOAD)
//   *_DEF         default DATA_W / DEPTH / NUM_VEC for imem_loadable
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    READY,
    LOAD
  } imem_state_t;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF   = 256;
  localparam int unsigned NUM_VEC_DEF = 2;

endpackage

// File: rtl/imem_array.sv
// imem_array: WORD_W x DEPTH storage with one write port and one registered read port.
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-low reset (clears the read register only)
//   we     in   write enable
//   waddr  in   write address (caller keeps it below DEPTH)
//   wdata  in   write word
//   re     in   read enable; rdata holds its value when low
//   raddr  in   read address; addresses >= DEPTH read as zero
//   rdata  out  registered read word
module imem_array #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              raddr_ok;

  assign raddr_ok = {1'b0, raddr} < DEPTH_A;

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= raddr_ok ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/imem_loadable.sv
// imem_loadable: parametrised instruction memory with handshaked load port,
// post-reset sequential clear, registered fetch port and NUM_VEC vector shadows.
// Optional feature macro: IMEM_LOADABLE_PARITY_EN (per-word even parity + parity_err).
// Ports:
//   CLK, RST               clock (rising edge), synchronous active-low reset
//   fetch_req, fetch_addr  fetch request/address, sampled every cycle in READY
//   fetch_valid, fetch_data registered fetch result, one cycle after request
//   load_en                request LOAD mode
//   load_valid, load_ready load beat handshake
//   load_addr, load_data   load beat address/word
//   busy                   clear sequence in progress
//   vec_out                words 0..NUM_VEC-1; word k at [k*DATA_W +: DATA_W]
//   parity_err             (macro only) fetched word failed its parity check
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned NUM_VEC = NUM_VEC_DEF,
  parameter int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_valid,
  output logic [DATA_W-1:0]         fetch_data,
  input  logic                      load_en,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [DATA_W-1:0]         load_data,
  output logic                      busy,
  output logic [NUM_VEC*DATA_W-1:0] vec_out
`ifdef IMEM_LOADABLE_PARITY_EN
  ,
  output logic                      parity_err
`endif
);

`ifdef IMEM_LOADABLE_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  imem_state_t       state;
  logic [ADDR_W-1:0] clr_ptr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [WORD_W-1:0] word_wdata;
  logic [WORD_W-1:0] rd_word;
  logic              rd_en;
  logic              load_addr_ok;

  assign load_addr_ok = {1'b0, load_addr} < DEPTH_A;
  assign rd_en        = (state == READY) && fetch_req;

  // Single write mux: clear pointer in CLEAR, accepted in-range beat in LOAD.
  // Gated by RST so a beat in the reset cycle cannot land.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = '0;
    if (RST) begin
      case (state)
        CLEAR: mem_we = 1'b1;
        LOAD: begin
          if (load_valid && load_ready && load_addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = load_addr;
            mem_wdata = load_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADABLE_PARITY_EN
  // Even parity: stored bit makes the total count of ones even.
  assign word_wdata = {^mem_wdata, mem_wdata};
  assign parity_err = fetch_valid && (^rd_word);
`else
  assign word_wdata = mem_wdata;
`endif

  assign fetch_data = rd_word[DATA_W-1:0];

  imem_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .CLK   (CLK),
    .RST   (RST),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (word_wdata),
    .re    (rd_en),
    .raddr (fetch_addr),
    .rdata (rd_word)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      fetch_valid <= 1'b0;
      load_ready  <= 1'b0;
      busy        <= 1'b1;
      vec_out     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          fetch_valid <= 1'b0;
          load_ready  <= 1'b0;
          if (clr_ptr == LAST) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: begin
          fetch_valid <= fetch_req;
          load_ready  <= 1'b0;
          if (load_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          fetch_valid <= 1'b0;
          if (!load_en) begin
            state      <= READY;
            load_ready <= 1'b0;
          end else begin
            load_ready <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
      // Vector shadows track every memory write to their address.
      for (int unsigned k = 0; k < NUM_VEC; k++) begin
        if (mem_we && ({1'b0, mem_waddr} == (ADDR_W+1)'(k))) begin
          vec_out[k*DATA_W +: DATA_W] <= mem_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       fetch_req = 1'b0;
  logic [7:0] fetch_addr = '0;
  logic       load_en = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_addr = '0;
  logic [7:0] load_data = '0;

  logic        fetch_valid, load_ready, busy;
  logic [7:0]  fetch_data;
  logic [15:0] vec_out;
  logic        fetch_valid_b, load_ready_b, busy_b;
  logic [7:0]  fetch_data_b;
  logic [15:0] vec_out_b;
`ifdef IMEM_LOADABLE_PARITY_EN
  logic        parity_err, parity_err_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  imem_loadable #(.DATA_W(8), .DEPTH(256), .NUM_VEC(2)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .load_en(load_en), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .vec_out(vec_out)
`ifdef IMEM_LOADABLE_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  imem_loadable #(.DATA_W(8), .DEPTH(200), .NUM_VEC(2)) dut_b (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid_b), .fetch_data(fetch_data_b),
    .load_en(load_en), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_addr(load_addr), .load_data(load_data),
    .busy(busy_b), .vec_out(vec_out_b)
`ifdef IMEM_LOADABLE_PARITY_EN
    , .parity_err(parity_err_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits for busy to drop on both instances (bounded) and checks clear length.
  task automatic wait_clear(input string tag);
    int cnt = 0, cnt_b = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      cnt++;
      if (!busy_b && cnt_b == 0) cnt_b = cnt;
      if (!busy) break;
      seen = seen | fetch_valid | load_ready;
    end
    check({tag, "_len256"}, cnt, 256);
    check({tag, "_len200"}, cnt_b, 200);
    check({tag, "_quiet"}, {31'd0, seen}, 0);
  endtask

  task automatic fetch(input string tag, input logic [7:0] addr,
                       input logic [7:0] exp_a, input logic [7:0] exp_b);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    step();
    check({tag, "_va"}, {31'd0, fetch_valid}, 1);
    check({tag, "_da"}, {24'd0, fetch_data}, {24'd0, exp_a});
    check({tag, "_vb"}, {31'd0, fetch_valid_b}, 1);
    check({tag, "_db"}, {24'd0, fetch_data_b}, {24'd0, exp_b});
    fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [7:0] b2b_addr [3] = '{8'h00, 8'h01, 8'h10};
  logic [7:0] b2b_data [3] = '{8'hA5, 8'h3C, 8'h7E};
  logic [7:0] ld_addr  [3] = '{8'h00, 8'h01, 8'h10};
  logic [7:0] ld_data  [3] = '{8'hA5, 8'h3C, 8'h7E};

  initial begin
    // Reset held two cycles
    step();
    step();
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_fv", {31'd0, fetch_valid}, 0);
    check("rst_fd", {24'd0, fetch_data}, 0);
    check("rst_lr", {31'd0, load_ready}, 0);
    check("rst_vec", {16'd0, vec_out}, 0);

    // Release; fetch and load attempts during clear must be ignored
    RST        = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    load_valid = 1'b1;
    load_addr  = 8'h10;
    load_data  = 8'hFF;
    wait_clear("clr1");
    fetch_req  = 1'b0;
    load_valid = 1'b0;
    fetch("f10_clr", 8'h10, 8'h00, 8'h00);
    step();
    check("idle_fv", {31'd0, fetch_valid}, 0);

    // Load three beats
    load_en = 1'b1;
    step();
    check("lr_entry", {31'd0, load_ready}, 0);
    step();
    check("lr_up", {31'd0, load_ready}, 1);
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_addr  = ld_addr[i];
      load_data  = ld_data[i];
      step();
      check("fv_in_load", {31'd0, fetch_valid}, 0);
    end
    load_valid = 1'b0;
    load_en    = 1'b0;
    fetch_req  = 1'b0;
    step();
    check("lr_drop", {31'd0, load_ready}, 0);
    check("vec_a", {16'd0, vec_out}, 32'h3CA5);
    check("vec_b", {16'd0, vec_out_b}, 32'h3CA5);
    fetch("f10_ld", 8'h10, 8'h7E, 8'h7E);

    // Back-to-back fetches
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = b2b_addr[i];
      step();
      check("b2b_v", {31'd0, fetch_valid}, 1);
      check("b2b_d", {24'd0, fetch_data}, {24'd0, b2b_data[i]});
    end
    fetch_req = 1'b0;
    step();
    check("b2b_vlow", {31'd0, fetch_valid}, 0);
    check("b2b_hold", {24'd0, fetch_data}, 32'h7E);

    // Out-of-range handling on the DEPTH=200 instance
    fetch("fFA", 8'hFA, 8'h00, 8'h00);
    load_en = 1'b1;
    step();
    step();
    load_valid = 1'b1;
    load_addr  = 8'hC8;
    load_data  = 8'h55;
    check("oor_lr_b", {31'd0, load_ready_b}, 1);
    step();
    load_valid = 1'b0;
    load_en    = 1'b0;
    step();
    fetch("fC8", 8'hC8, 8'h55, 8'h00);
    fetch("f48", 8'h48, 8'h00, 8'h00);
    fetch("f00", 8'h00, 8'hA5, 8'hA5);
    check("oor_vec_b", {16'd0, vec_out_b}, 32'h3CA5);

    // Reset in the middle of a load
    load_en = 1'b1;
    step();
    step();
    load_valid = 1'b1;
    load_addr  = 8'h10;
    load_data  = 8'h99;
    step();
    RST = 1'b0;
    step();
    check("mid_lr", {31'd0, load_ready}, 0);
    check("mid_busy", {31'd0, busy}, 1);
    check("mid_vec", {16'd0, vec_out}, 0);
    RST        = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    wait_clear("clr2");
    fetch("f10_rst", 8'h10, 8'h00, 8'h00);
    fetch("f01_rst", 8'h01, 8'h00, 8'h00);
    check("clr2_vec", {16'd0, vec_out}, 0);

`ifdef IMEM_LOADABLE_PARITY_EN
    check("par_clean", {31'd0, parity_err}, 0);
    dut.u_array.mem[1][8] = ~dut.u_array.mem[1][8];
    fetch("par_f01", 8'h01, 8'h00, 8'h00);
    check("par_err1", {31'd0, parity_err}, 1);
    fetch("par_f00", 8'h00, 8'h00, 8'h00);
    check("par_err0", {31'd0, parity_err}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
